// File: rtl/irq_timer.sv
// irq_timer: memory-mapped countdown timer driving one CP0 HW interrupt line.
// Register window: Addr 0 = CTRL, 1 = PRESET, 2 = COUNT (read-only), 3 = reserved.
// Optional build macro IRQ_TIMER_STATUS_EN maps Addr 3 to a STATUS register
// with write-1-to-clear of the interrupt flag.
//
// state | meaning
// IDLE  | stopped, waiting for CTRL.En
// LOAD  | copy PRESET into COUNT
// CNT   | counting down, fires when COUNT reaches the last step
// INT   | flag just raised; one-shot clears En, periodic clears flag and reloads
module irq_timer #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        we,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic [WIDTH-1:0]   preset_q, preset_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               irq_flag_q, irq_flag_d;

    logic               wr_ctrl;
    logic               wr_preset;

    assign wr_ctrl   = we && (Addr == 2'd0);
    assign wr_preset = we && (Addr == 2'd1);

    // State and register file update; reset wins over any concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Next-state logic: software clear first, FSM next, CTRL write last so a
    // software write to CTRL beats the hardware En clear in INT.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

`ifdef IRQ_TIMER_STATUS_EN
        if (we && (Addr == 2'd3) && Din[0]) begin
            irq_flag_d = 1'b0;
        end
`else
        if (wr_ctrl || wr_preset) begin
            irq_flag_d = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                if (en_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = INT;
                end
            end
            INT: begin
                state_d = IDLE;
                // Modes 10/11 fall back to one-shot behaviour.
                if (mode_q == 2'b01) begin
                    irq_flag_d = 1'b0;
                end else begin
                    en_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_ctrl) begin
            en_d   = Din[0];
            mode_d = Din[2:1];
            im_d   = Din[3];
        end
        if (wr_preset) begin
            preset_d = Din[WIDTH-1:0];
        end
    end

    // Combinational read mux for the selected word.
    always_comb begin
        Dout = 32'd0;
        case (Addr)
            2'd0: Dout = {28'd0, im_q, mode_q, en_q};
            2'd1: Dout = 32'(preset_q);
            2'd2: Dout = 32'(count_q);
`ifdef IRQ_TIMER_STATUS_EN
            2'd3: Dout = {30'd0, (state_q == CNT), irq_flag_q};
`else
            2'd3: Dout = 32'd0;
`endif
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag_q & im_q;

endmodule

// File: tb/tb_irq_timer.sv
// Directed bench for irq_timer: inputs change and outputs are sampled on the
// falling edge, so every rising edge sees stable inputs.
module tb_irq_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        we;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    irq_timer #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .we   (we),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One write; the rising edge inside is the write edge. Returns on the
    // falling edge right after it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = Dout;
    endtask

    logic [31:0] v;
    int          pulses;
    int          ph;
    logic [31:0] exp_cnt;

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        Addr  = 2'd0;
        Din   = 32'd0;
        tick(2);
        reset = 1'b0;

        // Reset state
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check($sformatf("reset_dout_addr%0d", a), v, 32'd0);
        end
        check("reset_irq", {31'd0, IRQ}, 32'd0);

        // One-shot, PRESET=5: flag rises at E7
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick(6);
        check("os_irq_e6", {31'd0, IRQ}, 32'd0);
        rd(2'd2, v);
        check("os_count_e6", v, 32'd1);
        tick(1);
        check("os_irq_e7", {31'd0, IRQ}, 32'd1);
        rd(2'd2, v);
        check("os_count_e7", v, 32'd0);
        tick(1);
        rd(2'd0, v);
        check("os_ctrl_e8", v, 32'h8);
        check("os_irq_e8", {31'd0, IRQ}, 32'd1);
        tick(3);
        check("os_irq_held", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'h8);
`ifdef IRQ_TIMER_STATUS_EN
        check("os_irq_ctrl_nowclr", {31'd0, IRQ}, 32'd1);
        wr(2'd3, 32'd1);
`endif
        check("os_irq_cleared", {31'd0, IRQ}, 32'd0);
        rd(2'd0, v);
        check("os_ctrl_after_clr", v, 32'h8);

        // Periodic, PRESET=3: period 6, pulse after E5, E11, E17, E23
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            ph = k % 6;
            case (ph)
                2: exp_cnt = 32'd3;
                3: exp_cnt = 32'd2;
                4: exp_cnt = 32'd1;
                default: exp_cnt = 32'd0;
            endcase
            if (IRQ === 1'b1) pulses++;
            check($sformatf("per_irq_e%0d", k), {31'd0, IRQ}, (ph == 5) ? 32'd1 : 32'd0);
            rd(2'd2, v);
            check($sformatf("per_count_e%0d", k), v, exp_cnt);
        end
        check("per_pulse_total", 32'(pulses), 32'd4);
        wr(2'd0, 32'h8);
        tick(3);
        check("per_stopped_irq", {31'd0, IRQ}, 32'd0);

        // Mid-count stop at COUNT=6; decrement lands on the write edge
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(6);
        rd(2'd2, v);
        check("mid_count_e6", v, 32'd6);
        wr(2'd0, 32'h8);
        tick(3);
        rd(2'd2, v);
        check("mid_count_frozen", v, 32'd5);
        check("mid_irq", {31'd0, IRQ}, 32'd0);
        wr(2'd0, 32'h9);
        tick(2);
        rd(2'd2, v);
        check("mid_reload", v, 32'd10);
        wr(2'd0, 32'h8);
        tick(2);
        rd(2'd2, v);
        check("mid_count_stop2", v, 32'd9);
        wr(2'd2, 32'hFFFF);
        rd(2'd2, v);
        check("count_write_ignored", v, 32'd9);

        // IM=0, PRESET=2: flag set but IRQ masked
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        tick(4);
        check("im0_irq_e4", {31'd0, IRQ}, 32'd0);
        tick(1);
        rd(2'd0, v);
        check("im0_ctrl_en_cleared", v, 32'h0);
`ifdef IRQ_TIMER_STATUS_EN
        rd(2'd3, v);
        check("im0_status", v, 32'd1);
        wr(2'd0, 32'h8);
        check("im0_irq_unmasked", {31'd0, IRQ}, 32'd1);
        wr(2'd3, 32'd1);
        check("im0_irq_w1c", {31'd0, IRQ}, 32'd0);
`else
        wr(2'd0, 32'h8);
        check("im0_irq_after_ctrl", {31'd0, IRQ}, 32'd0);
`endif

        // PRESET=0 fires at E3
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(2);
        check("p0_irq_e2", {31'd0, IRQ}, 32'd0);
        tick(1);
        check("p0_irq_e3", {31'd0, IRQ}, 32'd1);
        tick(1);
`ifdef IRQ_TIMER_STATUS_EN
        wr(2'd3, 32'd1);
`else
        wr(2'd0, 32'h8);
`endif
        check("p0_irq_cleared", {31'd0, IRQ}, 32'd0);

        // PRESET=1 fires at E3
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        tick(2);
        check("p1_irq_e2", {31'd0, IRQ}, 32'd0);
        tick(1);
        check("p1_irq_e3", {31'd0, IRQ}, 32'd1);
        rd(2'd2, v);
        check("p1_count_e3", v, 32'd0);
        tick(1);
`ifdef IRQ_TIMER_STATUS_EN
        rd(2'd3, v);
        check("p1_status", v, 32'd1);
        wr(2'd3, 32'd1);
        check("p1_irq_w1c", {31'd0, IRQ}, 32'd0);
`else
        wr(2'd3, 32'hFFFF_FFFF);
        check("p1_addr3_write_no_clear", {31'd0, IRQ}, 32'd1);
        rd(2'd3, v);
        check("p1_addr3_reads_zero", v, 32'd0);
        wr(2'd0, 32'h8);
        check("p1_irq_cleared", {31'd0, IRQ}, 32'd0);
`endif

        // Reset overrides a concurrent write
        reset = 1'b1;
        Addr  = 2'd1;
        Din   = 32'd7;
        we    = 1'b1;
        tick(1);
        reset = 1'b0;
        we    = 1'b0;
        rd(2'd1, v);
        check("rst_vs_we_preset", v, 32'd0);
        rd(2'd0, v);
        check("rst_vs_we_ctrl", v, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
